// File: rtl/move_sequencer.sv
// move_sequencer
// Sequences one robot move for the drive-control datapath. A move command
// (desired heading plus square count) first turns the robot in place until the
// heading error is small. It then ramps forward speed up, counts centre-line
// crossings, ramps speed back down and pulses move_done.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   cmd_vld       : move command valid
//   cmd_hdg[11:0] : desired heading (signed, wraps at 12 bits)
//   cmd_sqrs[3:0] : squares to travel (0 = turn only)
//   cmd_rdy       : sequencer can accept a command (IDLE only)
//   heading[11:0] : measured heading (signed)
//   heading_rdy   : single-cycle strobe, heading updated
//   cntrIR        : centre-line IR sensor (level)
//   moving        : enables heading PID and its integrator
//   err_vld       : heading_rdy qualified by moving
//   error[11:0]   : heading - desired heading (12-bit wrap)
//   frwrd[9:0]    : forward speed to the PID
//   move_done     : single-cycle completion pulse
//
// Command handshake: a command transfers on any rising clk edge where
// cmd_vld & cmd_rdy are both high. cmd_rdy is high only in IDLE and does not
// depend on cmd_vld. cmd_vld while cmd_rdy is low is ignored with no side effects.
module move_sequencer #(
  parameter logic [9:0]  MAX_FRWRD = 10'h2A0,
  parameter logic [9:0]  RAMP_INC  = 10'd3,
  parameter logic [11:0] HDG_TOL   = 12'd44
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vld,
  input  logic [11:0] cmd_hdg,
  input  logic [3:0]  cmd_sqrs,
  output logic        cmd_rdy,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  output logic        moving,
  output logic        err_vld,
  output logic [11:0] error,
  output logic [9:0]  frwrd,
  output logic        move_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TURN  = 3'd1,
    MOVE  = 3'd2,
    DECEL = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] des_hdg_q, des_hdg_d;
  logic [4:0]  target_q, target_d;
  logic [4:0]  sqr_cnt_q, sqr_cnt_d;
  logic        cntr_ir_q;
  logic [9:0]  frwrd_q, frwrd_d;

  logic        accept;
  logic [11:0] abs_err;
  logic        in_tol;
  logic        ir_rise;
  logic [4:0]  cnt_inc;
  logic        count_hit;
  logic [10:0] up_sum;
  logic [9:0]  up_sat;
  logic [9:0]  dec_step;
  logic [9:0]  dn_sat;

  assign accept  = cmd_vld & cmd_rdy;
  assign error   = heading - des_hdg_q;
  // Magnitude of a signed 12-bit value; 12'h800 maps to itself (2048) and so
  // is always treated as out of tolerance.
  assign abs_err = error[11] ? (~error + 12'd1) : error;
  assign in_tol  = (abs_err < HDG_TOL);
  assign ir_rise = cntrIR & ~cntr_ir_q;
  assign cnt_inc = sqr_cnt_q + 5'd1;
  // Target compare uses the value the counter is about to take, so DECEL
  // starts the cycle after the completing edge.
  assign count_hit = (state_q == MOVE) & ir_rise & (cnt_inc == target_q);

  // Ramp arithmetic, one bit wider on the way up so the clamp sees overflow.
  assign up_sum   = {1'b0, frwrd_q} + {1'b0, RAMP_INC};
  assign up_sat   = (up_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : up_sum[9:0];
  assign dec_step = {RAMP_INC[8:0], 1'b0};
  assign dn_sat   = (frwrd_q > dec_step) ? (frwrd_q - dec_step) : 10'd0;

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      des_hdg_q <= 12'd0;
      target_q  <= 5'd0;
      sqr_cnt_q <= 5'd0;
      cntr_ir_q <= 1'b0;
      frwrd_q   <= 10'd0;
    end else begin
      state_q   <= state_d;
      des_hdg_q <= des_hdg_d;
      target_q  <= target_d;
      sqr_cnt_q <= sqr_cnt_d;
      cntr_ir_q <= cntrIR;
      frwrd_q   <= frwrd_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = TURN;
      TURN:    if (heading_rdy && in_tol) state_d = (target_q == 5'd0) ? DONE : MOVE;
      MOVE:    if (count_hit) state_d = DECEL;
      DECEL:   if (frwrd_q == 10'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    des_hdg_d = des_hdg_q;
    target_d  = target_q;
    sqr_cnt_d = sqr_cnt_q;
    frwrd_d   = frwrd_q;
    case (state_q)
      IDLE: begin
        frwrd_d = 10'd0;
        if (accept) begin
          des_hdg_d = cmd_hdg;
          target_d  = {cmd_sqrs, 1'b0};
          sqr_cnt_d = 5'd0;
        end
      end
      MOVE: begin
        if (heading_rdy) frwrd_d = up_sat;
        if (ir_rise)     sqr_cnt_d = cnt_inc;
      end
      DECEL: begin
        if (heading_rdy) frwrd_d = dn_sat;
      end
      default: frwrd_d = 10'd0;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_rdy   = 1'b0;
    moving    = 1'b0;
    move_done = 1'b0;
    case (state_q)
      IDLE:    cmd_rdy = 1'b1;
      TURN,
      MOVE,
      DECEL:   moving = 1'b1;
      DONE:    move_done = 1'b1;
      default: cmd_rdy = 1'b0;
    endcase
  end

  assign err_vld = heading_rdy & moving;
  assign frwrd   = frwrd_q;

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer
// Directed bench for move_sequencer. Stimulus pushes every expected output
// event (frwrd changes and move_done pulses) onto exp_q; a monitor on the
// falling edge pops and compares whenever the DUT presents such an event.
module tb_move_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_vld;
  logic [11:0] cmd_hdg;
  logic [3:0]  cmd_sqrs;
  logic        cmd_rdy;
  logic [11:0] heading;
  logic        heading_rdy;
  logic        cntrIR;
  logic        moving;
  logic        err_vld;
  logic [11:0] error;
  logic [9:0]  frwrd;
  logic        move_done;

  int total = 0;
  int bad   = 0;

  // Event encoding: {4'h1, 2'b0, frwrd} for a speed change,
  // {4'h2, 1'b0, moving, frwrd} for a move_done pulse.
  logic [15:0] exp_q[$];
  logic [9:0]  prev_frwrd = 10'd0;

  move_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_vld     (cmd_vld),
    .cmd_hdg     (cmd_hdg),
    .cmd_sqrs    (cmd_sqrs),
    .cmd_rdy     (cmd_rdy),
    .heading     (heading),
    .heading_rdy (heading_rdy),
    .cntrIR      (cntrIR),
    .moving      (moving),
    .err_vld     (err_vld),
    .error       (error),
    .frwrd       (frwrd),
    .move_done   (move_done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking helpers
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string name, input logic [15:0] act);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected event actual=%h expected=none t=%0t", name, act, $time);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s actual=%h expected=%h t=%0t", name, act, e, $time);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (frwrd !== prev_frwrd) begin
      pop_check("frwrd_step", {4'h1, 2'b00, frwrd});
      prev_frwrd = frwrd;
    end
    if (move_done === 1'b1)
      pop_check("move_done", {4'h2, 1'b0, moving, frwrd});
  end

  // Driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hrdy();
    heading_rdy = 1'b1;
    tick();
    heading_rdy = 1'b0;
  endtask

  task automatic ir_pulse();
    cntrIR = 1'b1;
    tick();
    cntrIR = 1'b0;
  endtask

  task automatic push_frwrd(input logic [9:0] v);
    exp_q.push_back({4'h1, 2'b00, v});
  endtask

  task automatic push_done();
    exp_q.push_back(16'h2000);
  endtask

  task automatic send_cmd(input logic [11:0] hdg, input logic [3:0] sqrs);
    int waited;
    waited = 0;
    while (cmd_rdy !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    check("cmd_rdy_before_cmd", {15'd0, cmd_rdy}, 16'd1);
    cmd_vld  = 1'b1;
    cmd_hdg  = hdg;
    cmd_sqrs = sqrs;
    tick();
    cmd_vld  = 1'b0;
  endtask

  // Stimulus
  logic [11:0] turn_hdg [6] = '{12'hBFF, 12'h42B, 12'h100, 12'h200, 12'h300, 12'h3E0};
  logic [11:0] turn_err [6] = '{12'h800, 12'h02C, 12'hD01, 12'hE01, 12'hF01, 12'hFE1};

  initial begin
    logic [9:0] f;
    logic [9:0] nf;
    rst_n = 1'b1; cmd_vld = 1'b0; cmd_hdg = 12'd0; cmd_sqrs = 4'd0;
    heading = 12'd0; heading_rdy = 1'b0; cntrIR = 1'b0;
    #3 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;

    // Reset state, idle 20 cycles
    tick(20);
    check("reset_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
    check("reset_moving",  {15'd0, moving},  16'd0);
    check("reset_frwrd",   {6'd0, frwrd},    16'd0);
    check("reset_error",   {4'd0, error},    16'd0);
    heading_rdy = 1'b1; #1;
    check("idle_err_vld",  {15'd0, err_vld}, 16'd0);
    heading_rdy = 1'b0;

    // Turn-only move
    send_cmd(12'h3FF, 4'd0);
    check("turn_moving", {15'd0, moving}, 16'd1);
    check("turn_error0", {4'd0, error}, 16'hC01);
    for (int i = 0; i < 6; i++) begin
      heading = turn_hdg[i];
      heading_rdy = 1'b1;
      #1;
      check("turn_err_vld", {15'd0, err_vld}, 16'd1);
      check("turn_error", {4'd0, error}, {4'd0, turn_err[i]});
      if (i == 5) push_done();
      tick();
      heading_rdy = 1'b0;
      if (i < 5) check("turn_still_moving", {15'd0, moving}, 16'd1);
      tick(2);
    end
    check("turn_cmd_rdy_back", {15'd0, cmd_rdy}, 16'd1);
    check("turn_moving_off", {15'd0, moving}, 16'd0);

    // One square, plain ramp up/down
    heading = 12'd0;
    send_cmd(12'h000, 4'd1);
    tick(3);
    hrdy(); tick(3);
    for (int i = 1; i <= 10; i++) begin
      push_frwrd(10'(3 * i));
      hrdy(); tick(3);
    end
    check("sq1_frwrd30", {6'd0, frwrd}, 16'd30);
    ir_pulse(); tick(2);
    ir_pulse(); tick(2);
    push_frwrd(10'd24); push_frwrd(10'd18); push_frwrd(10'd12);
    push_frwrd(10'd6);  push_frwrd(10'd0);  push_done();
    for (int i = 0; i < 5; i++) begin
      hrdy(); tick(3);
    end
    check("sq1_cmd_rdy_back", {15'd0, cmd_rdy}, 16'd1);

    // Two squares, saturate at MAX_FRWRD then decelerate to 0
    send_cmd(12'h000, 4'd2);
    tick();
    hrdy(); tick();
    f = 10'd0;
    for (int i = 0; i < 400; i++) begin
      nf = (f + 10'd3 > 10'h2A0) ? 10'h2A0 : f + 10'd3;
      if (nf != f) push_frwrd(nf);
      f = nf;
      hrdy(); tick();
    end
    check("sq2_saturated", {6'd0, frwrd}, 16'h02A0);
    for (int e = 0; e < 4; e++) begin
      ir_pulse(); tick();
      if (e < 3) begin
        hrdy(); tick();
      end
    end
    for (int k = 1; k <= 112; k++) push_frwrd(10'h2A0 - 10'(6 * k));
    push_done();
    for (int k = 0; k < 112; k++) begin
      hrdy(); tick();
    end
    tick(4);
    check("sq2_cmd_rdy_back", {15'd0, cmd_rdy}, 16'd1);

    // Command ignored while moving; then reset mid-DECEL at frwrd=120
    heading = 12'h020;
    send_cmd(12'h010, 4'd1);
    tick();
    hrdy(); tick();
    for (int i = 1; i <= 42; i++) begin
      push_frwrd(10'(3 * i));
      hrdy(); tick();
      if (i == 20) begin
        cmd_vld = 1'b1; cmd_hdg = 12'h123; cmd_sqrs = 4'd0;
        tick();
        cmd_vld = 1'b0;
        check("ignored_cmd_error", {4'd0, error}, 16'h0010);
        check("ignored_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("ignored_cmd_moving", {15'd0, moving}, 16'd1);
      end
    end
    ir_pulse(); tick();
    ir_pulse(); tick();
    push_frwrd(10'd120);
    hrdy(); tick();
    check("decel_frwrd120", {6'd0, frwrd}, 16'd120);
    push_frwrd(10'd0);
    rst_n = 1'b0;
    #1;
    check("rst_frwrd", {6'd0, frwrd}, 16'd0);
    check("rst_moving", {15'd0, moving}, 16'd0);
    tick(2);
    rst_n = 1'b1;
    tick();
    check("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);

    // New command after reset: TURN-phase edge not counted, simultaneous
    // completing edge + heading_rdy, and ramp-down floor at 0.
    heading = 12'd0;
    send_cmd(12'h000, 4'd1);
    ir_pulse(); tick(2);
    hrdy(); tick();
    push_frwrd(10'd3); push_frwrd(10'd6); push_frwrd(10'd9);
    push_frwrd(10'd3); push_frwrd(10'd0); push_done();
    hrdy(); tick();
    hrdy(); tick();
    ir_pulse(); tick();
    cntrIR = 1'b1; heading_rdy = 1'b1;
    tick();
    cntrIR = 1'b0; heading_rdy = 1'b0;
    tick();
    hrdy(); tick();
    hrdy(); tick();
    tick(3);
    check("last_cmd_rdy_back", {15'd0, cmd_rdy}, 16'd1);

    tick(4);
    check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout actual=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Sequences one robot move for the drive-control datapath.
- Accepts a move command (desired heading plus square count) and turns in place until heading error is small.
- Ramps forward speed up, counts centre-line crossings, then ramps down and reports completion.
- Drives the heading-PID controller's moving, err_vld, error and frwrd inputs.

Parameters:
- MAX_FRWRD, 10'h2A0, forward-speed ceiling reached during the ramp.
- RAMP_INC, 10'd3, frwrd increment per heading_rdy during ramp-up; ramp-down decrement is 2*RAMP_INC.
- HDG_TOL, 12'd44, absolute heading error below which the turn phase is complete.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  move command valid
- cmd_hdg  in  12  desired heading, signed, wraps at 12 bits
- cmd_sqrs  in  4  squares to travel, unsigned; 0 = turn only
- cmd_rdy  out  1  sequencer can accept a command
- heading  in  12  measured heading, signed
- heading_rdy  in  1  single-cycle strobe: heading updated
- cntrIR  in  1  centre-line IR sensor, level
- moving  out  1  enables PID and integrator
- err_vld  out  1  equals heading_rdy while moving, else 0
- error  out  12  heading − desired heading, signed, 12-bit wrap
- frwrd  out  10  forward speed to PID
- move_done  out  1  single-cycle completion pulse

Behaviour:
- Reset: clk and rst_n are as given above (asynchronous active-low reset, clock clk).
  - State IDLE; frwrd=0, moving=0, move_done=0, err_vld=0.
  - Desired-heading register = 0; square counter = 0; cntrIR edge flop = 0.
  - cmd_rdy=1 out of reset.
- Handshake:
  - A command is accepted on the cycle cmd_vld & cmd_rdy.
  - cmd_hdg is latched to the desired-heading register; target = 2*cmd_sqrs (5 bits) is latched.
  - The square counter is cleared; the state is TURN on the next cycle.
  - cmd_rdy=1 only in IDLE; cmd_vld in other states is ignored with no side effects.
- error = heading − desired heading, 12-bit two's-complement subtract with natural wrap; no saturation here, the PID saturates. The error output is valid in every state.
- State machine:
  - IDLE: moving=0, frwrd=0. Exits on accept.
  - TURN: moving=1, frwrd=0.
    - On heading_rdy with |error| < HDG_TOL: go to DONE if target==0, else to MOVE.
    - |error| is signed magnitude; error=12'h800 counts as out of tolerance.
  - MOVE: moving=1.
    - On each heading_rdy, frwrd = min(frwrd+RAMP_INC, MAX_FRWRD); never exceeds MAX_FRWRD.
    - Each cntrIR rising edge (registered previous value) increments the square counter.
    - When the counter equals target (checked the cycle the count updates): go to DECEL.
  - DECEL: moving=1.
    - On each heading_rdy, frwrd = frwrd − 2*RAMP_INC, saturating at 0; no underflow wrap.
    - When frwrd==0: go to DONE.
  - DONE: move_done=1 for exactly one cycle, moving=0, frwrd=0; next state IDLE, so cmd_rdy returns the following cycle.
- err_vld = heading_rdy & moving, combinational.
- frwrd, state and counter are registered; frwrd changes only in the cycle after heading_rdy.
- Simultaneous events:
  - A cntrIR rising edge and heading_rdy in the same MOVE cycle: both take effect.
  - If the edge completes the count, the ramp increment of that cycle still applies and DECEL starts next cycle.
- cntrIR edges outside MOVE are not counted, but the edge flop still tracks cntrIR.
- Reset asserted mid-move: immediate return to reset values, with no move_done pulse.

Test Plan:
- Reset, then idle 20 cycles -> cmd_rdy=1, moving=0, frwrd=0, move_done never asserted.
- cmd_hdg=12'h3FF, cmd_sqrs=0; heading steps from 0 toward 12'h3FF on heading_rdy; within tolerance at 12'h3E0 -> moving=1 during TURN, frwrd stays 0, one move_done pulse, then cmd_rdy=1.
- cmd_hdg=0, cmd_sqrs=1, heading=0: heading_rdy every 4 cycles, two cntrIR pulses after frwrd=30 -> frwrd steps +3 per heading_rdy; after 2nd edge steps −6 to 0; move_done one cycle after frwrd reaches 0.
- cmd_sqrs=2, no cntrIR for 400 heading_rdy -> frwrd saturates at 10'h2A0 exactly; then 4 cntrIR edges -> DECEL, frwrd 2A0→29A→…→0 with no wrap.
- While in MOVE, pulse cmd_vld with a new cmd_hdg -> ignored; the desired heading is unchanged and error is unaffected.
- Drop rst_n mid-DECEL with frwrd=120 -> frwrd=0, moving=0 immediately, no move_done; after release cmd_rdy=1 and a new command works.
